opnd_fetch: RTL and testbench
=============================

# opnd_fetch

Parameterised operand-fetch stage between decode and execute. It holds one decoded instruction and reads the integer register file and CSR file. It resolves RAW hazards by forwarding from NUM_FWD younger-than-regfile pipeline stages, and stalls only when a matching producer's data is not yet available or a CSR write is pending. It replaces stall-on-any-match operand handling with per-source bypass, and supports configurable width and source count.

## Interface
Parameters:
- XLEN, 32, datapath width
- NUM_FWD, 3, forwarding sources; index 0 = youngest (EXU), NUM_FWD-1 = oldest (WBU)
- REG_AW, 5, register index width
- CSR_AW, 12, CSR address width
- PAYLOAD_W, 96, opaque control bits carried from decode to execute

Ports (reset is asynchronous, active-low; clock and reset named `clock`, `reset`):
- clock  in  1  clock
- reset  in  1  async active-low reset
- flush_i  in  1  branch/exception/mret flush
- in_valid_i  in  1  decode entry valid
- in_ready_o  out  1  stage can accept
- in_pc_i  in  XLEN  pc
- in_rs1_i, in_rs2_i  in  REG_AW  source indices
- in_rs1_en_i, in_rs2_en_i  in  1  source actually used
- in_csr_addr_i  in  CSR_AW  csr address; in_csr_en_i  in  1  csr read used
- in_payload_i  in  PAYLOAD_W  pass-through control
- rf_rs1_o, rf_rs2_o  out  REG_AW  regfile read indices (from held entry)
- rf_rs1_data_i, rf_rs2_data_i  in  XLEN  regfile read data (combinational)
- csr_addr_o  out  CSR_AW; csr_data_i  in  XLEN
- fwd_valid_i  in  NUM_FWD  source holds a valid instruction
- fwd_rd_we_i  in  NUM_FWD  source writes rd
- fwd_rd_i  in  NUM_FWD*REG_AW  source rd
- fwd_data_rdy_i  in  NUM_FWD  source result is final (0 for load in flight)
- fwd_data_i  in  NUM_FWD*XLEN  source result
- fwd_csr_we_i  in  NUM_FWD; fwd_csr_addr_i  in  NUM_FWD*CSR_AW
- out_valid_o  out  1; out_ready_i  in  1
- out_pc_o  out  XLEN; out_rs1_val_o, out_rs2_val_o, out_csr_val_o  out  XLEN; out_payload_o  out  PAYLOAD_W
- stall_cnt_o, ldu_cnt_o  out  32  (only with OPND_FETCH_PERF_EN)

## Operation
- One-entry holding register with `valid`. Loaded on in_valid_i && in_ready_o.
- Per source s ∈ {rs1, rs2}:
  - The source is zero if its index == 0 or its enable is low. Result 0, never stalls.
  - Otherwise match[i] = fwd_valid_i[i] && fwd_rd_we_i[i] && fwd_rd_i[i] == index.
  - The lowest matching i wins. If fwd_data_rdy_i[i], the value is fwd_data_i[i]; else the source is stalled.
  - With no match, the value is rf data.
- CSR: csr_stall = in_csr_en && any(fwd_valid_i[i] && fwd_csr_we_i[i] && fwd_csr_addr_i[i] == csr_addr). There is no CSR forwarding. With no stall, out_csr_val_o = csr_data_i.
- stall = valid && (rs1_stall || rs2_stall || csr_stall).
- out_valid_o = valid && !stall && !flush_i.
- in_ready_o = !valid || (out_valid_o && out_ready_i).
- Next `valid`:
  - Flush has top priority: valid becomes 0, and any same-cycle input is dropped.
  - Otherwise, on accept, valid becomes 1.
  - Otherwise, on out_valid_o && out_ready_i, valid becomes 0.
  - Otherwise valid holds.
- Payload, pc and indices are registered without reset, and are only meaningful when valid.

## Timing
- Reset values: valid=0, out_valid_o=0, in_ready_o=1, counters=0.
- Latency: an entry accepted at edge N is presented at cycle N+1 if no hazard. Back-to-back throughput is 1/cycle when out_ready_i=1.
- Operand values are combinational from the held entry and fwd/rf inputs. They are re-evaluated every cycle, so a stalled load-use resolves the cycle fwd_data_rdy_i rises.
- Simultaneous drain and accept in one cycle keeps valid=1 with the new entry.
- out_ready_i=0 with no stall: the entry and its operands stay stable, and the values track forwarding changes.
- Reset mid-operation clears valid asynchronously. The first accept is possible on the first edge after deassertion.
- in_ready_o depends combinationally on out_ready_i and fwd inputs. The downstream must not derive out_ready_i from in_valid_i.

## Configuration
- OPND_FETCH_PERF_EN defined:
  - stall_cnt_o increments every cycle valid && stall && !flush_i.
  - ldu_cnt_o increments when the stall is caused only by a not-ready forward source.
  - Both counters wrap at 2^32.
- OPND_FETCH_PERF_EN undefined: the counter ports are absent and no counter logic is built.

## Test plan
- Reset, then in_valid with rs1=3, rs2=0, rf_rs1_data=0x11, no fwd -> out_valid the next cycle, rs1_val=0x11, rs2_val=0.
- rs1=5; fwd[0] and fwd[2] both rd=5, we=1, rdy=1, data 0xA0 / 0xC0 -> rs1_val=0xA0 (youngest wins), no stall.
- rs2=7; fwd[0] rd=7, rdy=0 for 2 cycles, then rdy=1 with 0x55 -> out_valid low for 2 cycles, then high with rs2_val=0x55. With PERF_EN: stall_cnt=2, ldu_cnt=2.
- csr_en, addr 0x300; fwd[1] csr_we at 0x300 for 1 cycle -> one stall cycle, then out_csr_val=csr_data_i.
- Stalled entry plus in_valid plus flush_i in the same cycle -> valid=0 next cycle, out_valid=0 during the flush cycle, and the new entry is dropped.
- Stream of 4 entries with out_ready=0 for cycle 2 only -> all 4 emitted in order, the second held for exactly one extra cycle, and no duplicates.

Source files
------------

// File: rtl/opnd_fetch.sv
// Operand-fetch stage: one held decode entry, per-source bypass from NUM_FWD producers, CSR-write stall.
// Define OPND_FETCH_PERF_EN to build the stall_cnt_o / ldu_cnt_o performance counters.
module opnd_fetch #(
    parameter int XLEN      = 32,
    parameter int NUM_FWD   = 3,
    parameter int REG_AW    = 5,
    parameter int CSR_AW    = 12,
    parameter int PAYLOAD_W = 96
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [XLEN-1:0]           in_pc_i,
    input  logic [REG_AW-1:0]         in_rs1_i,
    input  logic [REG_AW-1:0]         in_rs2_i,
    input  logic                      in_rs1_en_i,
    input  logic                      in_rs2_en_i,
    input  logic [CSR_AW-1:0]         in_csr_addr_i,
    input  logic                      in_csr_en_i,
    input  logic [PAYLOAD_W-1:0]      in_payload_i,
    output logic [REG_AW-1:0]         rf_rs1_o,
    output logic [REG_AW-1:0]         rf_rs2_o,
    input  logic [XLEN-1:0]           rf_rs1_data_i,
    input  logic [XLEN-1:0]           rf_rs2_data_i,
    output logic [CSR_AW-1:0]         csr_addr_o,
    input  logic [XLEN-1:0]           csr_data_i,
    input  logic [NUM_FWD-1:0]        fwd_valid_i,
    input  logic [NUM_FWD-1:0]        fwd_rd_we_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
    input  logic [NUM_FWD-1:0]        fwd_data_rdy_i,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
    input  logic [NUM_FWD-1:0]        fwd_csr_we_i,
    input  logic [NUM_FWD*CSR_AW-1:0] fwd_csr_addr_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [XLEN-1:0]           out_pc_o,
    output logic [XLEN-1:0]           out_rs1_val_o,
    output logic [XLEN-1:0]           out_rs2_val_o,
    output logic [XLEN-1:0]           out_csr_val_o,
`ifdef OPND_FETCH_PERF_EN
    output logic [31:0]               stall_cnt_o,
    output logic [31:0]               ldu_cnt_o,
`endif
    output logic [PAYLOAD_W-1:0]      out_payload_o
);

    logic                 valid_r;
    logic [XLEN-1:0]      pc_r;
    logic [REG_AW-1:0]    rs1_r;
    logic [REG_AW-1:0]    rs2_r;
    logic                 rs1_en_r;
    logic                 rs2_en_r;
    logic [CSR_AW-1:0]    csr_addr_r;
    logic                 csr_en_r;
    logic [PAYLOAD_W-1:0] payload_r;

    logic [XLEN:0]        rs1_res_s;
    logic [XLEN:0]        rs2_res_s;
    logic                 rs_stall_s;
    logic                 csr_stall_s;
    logic                 stall_s;
    logic                 fire_out_s;
    logic                 accept_s;
    logic                 load_s;
    logic                 valid_nxt_s;

    // Returns {stall, value}; the youngest matching producer wins, its data used only once final.
    function automatic logic [XLEN:0] resolve_src(
        input logic [REG_AW-1:0]         idx,
        input logic                      en,
        input logic [XLEN-1:0]           rf_data,
        input logic [NUM_FWD-1:0]        f_valid,
        input logic [NUM_FWD-1:0]        f_we,
        input logic [NUM_FWD*REG_AW-1:0] f_rd,
        input logic [NUM_FWD-1:0]        f_rdy,
        input logic [NUM_FWD*XLEN-1:0]   f_data
    );
        logic [XLEN:0] res;
        logic          hit;
        res = {1'b0, rf_data};
        hit = 1'b0;
        if ((idx == {REG_AW{1'b0}}) || !en) begin
            res = {(XLEN+1){1'b0}};
        end else begin
            for (int i = 0; i < NUM_FWD; i++) begin
                if (!hit && f_valid[i] && f_we[i] && (f_rd[i*REG_AW +: REG_AW] == idx)) begin
                    hit = 1'b1;
                    res = f_rdy[i] ? {1'b0, f_data[i*XLEN +: XLEN]} : {1'b1, {XLEN{1'b0}}};
                end else begin
                    hit = hit;
                end
            end
        end
        return res;
    endfunction

    // Operand resolution for both integer sources from the held entry.
    always_comb begin
        rs1_res_s = resolve_src(rs1_r, rs1_en_r, rf_rs1_data_i, fwd_valid_i, fwd_rd_we_i,
                                fwd_rd_i, fwd_data_rdy_i, fwd_data_i);
        rs2_res_s = resolve_src(rs2_r, rs2_en_r, rf_rs2_data_i, fwd_valid_i, fwd_rd_we_i,
                                fwd_rd_i, fwd_data_rdy_i, fwd_data_i);
    end

    // CSR reads wait for any in-flight write to the same address; there is no CSR bypass.
    always_comb begin
        csr_stall_s = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (csr_en_r && fwd_valid_i[i] && fwd_csr_we_i[i] &&
                (fwd_csr_addr_i[i*CSR_AW +: CSR_AW] == csr_addr_r)) begin
                csr_stall_s = 1'b1;
            end else begin
                csr_stall_s = csr_stall_s;
            end
        end
    end

    assign rs_stall_s  = rs1_res_s[XLEN] || rs2_res_s[XLEN];
    assign stall_s     = valid_r && (rs_stall_s || csr_stall_s);
    assign out_valid_o = valid_r && !stall_s && !flush_i;
    assign fire_out_s  = out_valid_o && out_ready_i;
    assign in_ready_o  = !valid_r || fire_out_s;
    assign accept_s    = in_valid_i && in_ready_o;
    assign load_s      = accept_s && !flush_i;

    // Next-valid: flush beats accept, accept beats drain.
    always_comb begin
        valid_nxt_s = valid_r;
        if (flush_i) begin
            valid_nxt_s = 1'b0;
        end else if (accept_s) begin
            valid_nxt_s = 1'b1;
        end else if (fire_out_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // Entry valid flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_nxt_s;
        end
    end

    // Entry contents carry no reset; they are only meaningful while valid_r is set.
    always_ff @(posedge clock) begin
        if (load_s) begin
            pc_r       <= in_pc_i;
            rs1_r      <= in_rs1_i;
            rs2_r      <= in_rs2_i;
            rs1_en_r   <= in_rs1_en_i;
            rs2_en_r   <= in_rs2_en_i;
            csr_addr_r <= in_csr_addr_i;
            csr_en_r   <= in_csr_en_i;
            payload_r  <= in_payload_i;
        end
    end

    assign rf_rs1_o      = rs1_r;
    assign rf_rs2_o      = rs2_r;
    assign csr_addr_o    = csr_addr_r;
    assign out_pc_o      = pc_r;
    assign out_payload_o = payload_r;
    assign out_rs1_val_o = rs1_res_s[XLEN-1:0];
    assign out_rs2_val_o = rs2_res_s[XLEN-1:0];
    assign out_csr_val_o = csr_data_i;

`ifdef OPND_FETCH_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] ldu_cnt_r;

    // Stall and load-use counters; a load-use stall has no CSR component.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'd0;
            ldu_cnt_r   <= 32'd0;
        end else if (stall_s && !flush_i) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
            ldu_cnt_r   <= csr_stall_s ? ldu_cnt_r : (ldu_cnt_r + 32'd1);
        end
    end

    assign stall_cnt_o = stall_cnt_r;
    assign ldu_cnt_o   = ldu_cnt_r;
`endif

endmodule

// File: tb/tb_opnd_fetch.sv
// Self-checking bench for opnd_fetch: directed scenarios, then random traffic against a rule-level model.
module tb_opnd_fetch;
    localparam int XLEN = 32;
    localparam int NF   = 3;
    localparam int RA   = 5;
    localparam int CA   = 12;
    localparam int PW   = 96;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic             flush_i, in_valid_i, in_ready_o;
    logic [XLEN-1:0]  in_pc_i;
    logic [RA-1:0]    in_rs1_i, in_rs2_i;
    logic             in_rs1_en_i, in_rs2_en_i;
    logic [CA-1:0]    in_csr_addr_i;
    logic             in_csr_en_i;
    logic [PW-1:0]    in_payload_i;
    logic [RA-1:0]    rf_rs1_o, rf_rs2_o;
    logic [XLEN-1:0]  rf_rs1_data_i, rf_rs2_data_i;
    logic [CA-1:0]    csr_addr_o;
    logic [XLEN-1:0]  csr_data_i;
    logic [NF-1:0]    fwd_valid_i, fwd_rd_we_i, fwd_data_rdy_i, fwd_csr_we_i;
    logic [NF*RA-1:0] fwd_rd_i;
    logic [NF*XLEN-1:0] fwd_data_i;
    logic [NF*CA-1:0] fwd_csr_addr_i;
    logic             out_valid_o, out_ready_i;
    logic [XLEN-1:0]  out_pc_o, out_rs1_val_o, out_rs2_val_o, out_csr_val_o;
    logic [PW-1:0]    out_payload_o;
`ifdef OPND_FETCH_PERF_EN
    logic [31:0]      stall_cnt_o, ldu_cnt_o;
`endif

    logic [XLEN-1:0] rf_mem [32];
    logic [XLEN-1:0] csr_salt;
    assign rf_rs1_data_i = rf_mem[rf_rs1_o];
    assign rf_rs2_data_i = rf_mem[rf_rs2_o];
    assign csr_data_i    = csr_salt ^ {20'h0, csr_addr_o};

    opnd_fetch #(.XLEN(XLEN), .NUM_FWD(NF), .REG_AW(RA), .CSR_AW(CA), .PAYLOAD_W(PW)) dut (
        .clock(clock), .reset(reset), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rs1_en_i(in_rs1_en_i), .in_rs2_en_i(in_rs2_en_i),
        .in_csr_addr_i(in_csr_addr_i), .in_csr_en_i(in_csr_en_i), .in_payload_i(in_payload_i),
        .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o), .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .csr_addr_o(csr_addr_o), .csr_data_i(csr_data_i),
        .fwd_valid_i(fwd_valid_i), .fwd_rd_we_i(fwd_rd_we_i), .fwd_rd_i(fwd_rd_i),
        .fwd_data_rdy_i(fwd_data_rdy_i), .fwd_data_i(fwd_data_i),
        .fwd_csr_we_i(fwd_csr_we_i), .fwd_csr_addr_i(fwd_csr_addr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
        .out_rs1_val_o(out_rs1_val_o), .out_rs2_val_o(out_rs2_val_o), .out_csr_val_o(out_csr_val_o),
`ifdef OPND_FETCH_PERF_EN
        .stall_cnt_o(stall_cnt_o), .ldu_cnt_o(ldu_cnt_o),
`endif
        .out_payload_o(out_payload_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference state: the single entry the stage should be holding.
    logic            m_valid = 1'b0;
    logic [XLEN-1:0] m_pc;
    logic [RA-1:0]   m_rs1 = 5'd0, m_rs2 = 5'd0;
    logic            m_rs1_en, m_rs2_en, m_csr_en;
    logic [CA-1:0]   m_csr;
    logic [PW-1:0]   m_pay;
    logic [31:0]     m_stall = 32'd0, m_ldu = 32'd0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural value of a source: zero reg, youngest producer, else register file.
    function automatic logic [XLEN:0] ref_src(input logic [RA-1:0] idx, input logic en);
        if (idx == 5'd0 || !en) return {(XLEN+1){1'b0}};
        for (int i = 0; i < NF; i++) begin
            if (fwd_valid_i[i] && fwd_rd_we_i[i] && fwd_rd_i[i*RA +: RA] == idx)
                return fwd_data_rdy_i[i] ? {1'b0, fwd_data_i[i*XLEN +: XLEN]} : {1'b1, 32'h0};
        end
        return {1'b0, rf_mem[idx]};
    endfunction

    // Called at mid-cycle: compare, advance the model across the coming edge, then wait for it.
    task automatic model_tick();
        logic [XLEN:0] r1, r2;
        logic cst, st, ov, ir;
        r1 = ref_src(m_rs1, m_rs1_en);
        r2 = ref_src(m_rs2, m_rs2_en);
        cst = 1'b0;
        for (int i = 0; i < NF; i++)
            if (m_csr_en && fwd_valid_i[i] && fwd_csr_we_i[i] && fwd_csr_addr_i[i*CA +: CA] == m_csr)
                cst = 1'b1;
        st = m_valid && (r1[XLEN] || r2[XLEN] || cst);
        ov = m_valid && !st && !flush_i;
        ir = !m_valid || (ov && out_ready_i);
        chk("out_valid", out_valid_o, ov);
        chk("in_ready", in_ready_o, ir);
        if (ov) begin
            chk("out_pc", out_pc_o, m_pc);
            chk("rs1_val", out_rs1_val_o, r1[XLEN-1:0]);
            chk("rs2_val", out_rs2_val_o, r2[XLEN-1:0]);
            chk("csr_val", out_csr_val_o, csr_salt ^ {20'h0, m_csr});
            chk("payload", out_payload_o, m_pay);
        end
`ifdef OPND_FETCH_PERF_EN
        chk("stall_cnt", stall_cnt_o, m_stall);
        chk("ldu_cnt", ldu_cnt_o, m_ldu);
`endif
        if (st && !flush_i) begin
            m_stall = m_stall + 32'd1;
            if (!cst) m_ldu = m_ldu + 32'd1;
        end
        if (flush_i) m_valid = 1'b0;
        else if (in_valid_i && ir) begin
            m_valid = 1'b1; m_pc = in_pc_i; m_rs1 = in_rs1_i; m_rs2 = in_rs2_i;
            m_rs1_en = in_rs1_en_i; m_rs2_en = in_rs2_en_i; m_csr = in_csr_addr_i;
            m_csr_en = in_csr_en_i; m_pay = in_payload_i;
        end else if (ov && out_ready_i) m_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic clr_fwd();
        fwd_valid_i = '0; fwd_rd_we_i = '0; fwd_rd_i = '0; fwd_data_rdy_i = '0;
        fwd_data_i = '0; fwd_csr_we_i = '0; fwd_csr_addr_i = '0;
    endtask

    task automatic set_fwd(input int i, input logic [RA-1:0] rd, input logic rdy, input logic [XLEN-1:0] d);
        fwd_valid_i[i] = 1'b1; fwd_rd_we_i[i] = 1'b1; fwd_rd_i[i*RA +: RA] = rd;
        fwd_data_rdy_i[i] = rdy; fwd_data_i[i*XLEN +: XLEN] = d;
    endtask

    task automatic load(input logic [XLEN-1:0] pc, input logic [RA-1:0] r1, input logic e1,
                        input logic [RA-1:0] r2, input logic e2, input logic [CA-1:0] ca, input logic ce);
        in_valid_i = 1'b1; in_pc_i = pc; in_rs1_i = r1; in_rs1_en_i = e1; in_rs2_i = r2;
        in_rs2_en_i = e2; in_csr_addr_i = ca; in_csr_en_i = ce;
        in_payload_i = {pc, ~pc, pc ^ 32'hA5A5A5A5};
    endtask

    initial begin
        logic [31:0] base_st, base_ldu;
        logic [31:0] em[$];
        int k, hold1;
        reset = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1; csr_salt = 32'h5A5A0000;
        load(32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 12'h0, 1'b0); in_valid_i = 1'b0;
        clr_fwd();
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        rf_mem[0] = 32'hDEAD0000;
        rf_mem[3] = 32'h11;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_in_ready", in_ready_o, 1'b1);
`ifdef OPND_FETCH_PERF_EN
        chk("rst_stall_cnt", stall_cnt_o, 32'd0);
        chk("rst_ldu_cnt", ldu_cnt_o, 32'd0);
`endif
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;

        // Basic: rs1 from regfile, rs2 is x0.
        load(32'h100, 5'd3, 1'b1, 5'd0, 1'b1, 12'h0, 1'b0);
        @(negedge clock); chk("t1_accept", in_ready_o, 1'b1); model_tick();
        in_valid_i = 1'b0;
        @(negedge clock);
        chk("t1_out_valid", out_valid_o, 1'b1);
        chk("t1_rs1", out_rs1_val_o, 32'h11);
        chk("t1_rs2", out_rs2_val_o, 32'h0);
        model_tick();

        // Youngest producer wins.
        load(32'h104, 5'd5, 1'b1, 5'd0, 1'b0, 12'h0, 1'b0);
        set_fwd(0, 5'd5, 1'b1, 32'hA0); set_fwd(2, 5'd5, 1'b1, 32'hC0);
        @(negedge clock); model_tick();
        in_valid_i = 1'b0;
        @(negedge clock);
        chk("t2_out_valid", out_valid_o, 1'b1);
        chk("t2_rs1", out_rs1_val_o, 32'hA0);
        model_tick();
        clr_fwd();

        // Load-use: two not-ready cycles, then data arrives.
        load(32'h108, 5'd5, 1'b0, 5'd7, 1'b1, 12'h0, 1'b0);
        @(negedge clock); model_tick();
        in_valid_i = 1'b0;
        set_fwd(0, 5'd7, 1'b0, 32'h66);
`ifdef OPND_FETCH_PERF_EN
        base_st = stall_cnt_o; base_ldu = ldu_cnt_o;
`else
        base_st = 32'd0; base_ldu = 32'd0;
`endif
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk("t3_stalled", out_valid_o, 1'b0);
            chk("t3_no_accept", in_ready_o, 1'b0);
            model_tick();
        end
        set_fwd(0, 5'd7, 1'b1, 32'h55);
        @(negedge clock);
        chk("t3_out_valid", out_valid_o, 1'b1);
        chk("t3_rs2", out_rs2_val_o, 32'h55);
        chk("t3_rs1_disabled", out_rs1_val_o, 32'h0);
`ifdef OPND_FETCH_PERF_EN
        chk("t3_stall_delta", stall_cnt_o - base_st, 32'd2);
        chk("t3_ldu_delta", ldu_cnt_o - base_ldu, 32'd2);
`endif
        model_tick();
        clr_fwd();

        // CSR write in flight stalls one cycle.
        load(32'h10C, 5'd0, 1'b0, 5'd0, 1'b0, 12'h300, 1'b1);
        @(negedge clock); model_tick();
        in_valid_i = 1'b0;
        fwd_valid_i[1] = 1'b1; fwd_csr_we_i[1] = 1'b1; fwd_csr_addr_i[CA +: CA] = 12'h300;
        @(negedge clock); chk("t4_csr_stall", out_valid_o, 1'b0); model_tick();
        clr_fwd();
        @(negedge clock);
        chk("t4_out_valid", out_valid_o, 1'b1);
        chk("t4_csr_val", out_csr_val_o, 32'h5A5A0300);
        model_tick();

        // Flush of a stalled entry with a new input in the same cycle.
        load(32'h110, 5'd9, 1'b1, 5'd0, 1'b0, 12'h0, 1'b0);
        @(negedge clock); model_tick();
        in_valid_i = 1'b0; set_fwd(0, 5'd9, 1'b0, 32'h0);
        @(negedge clock); chk("t5_stalled", out_valid_o, 1'b0); model_tick();
        load(32'h114, 5'd1, 1'b1, 5'd0, 1'b0, 12'h0, 1'b0); flush_i = 1'b1;
        @(negedge clock); chk("t5_flush_ov", out_valid_o, 1'b0); model_tick();
        in_valid_i = 1'b0; flush_i = 1'b0; clr_fwd();
        @(negedge clock);
        chk("t5_after_ov", out_valid_o, 1'b0);
        chk("t5_after_ready", in_ready_o, 1'b1);
        model_tick();
        load(32'h118, 5'd1, 1'b1, 5'd0, 1'b0, 12'h0, 1'b0); flush_i = 1'b1;
        @(negedge clock); model_tick();
        in_valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clock); chk("t5_dropped", out_valid_o, 1'b0); model_tick();

        // Stream of four with one back-pressure cycle.
        k = 0; hold1 = 0;
        for (int c = 0; c < 8; c++) begin
            load(32'h200 + 32'(k), 5'd2, 1'b1, 5'd4, 1'b1, 12'h0, 1'b0);
            in_valid_i = (k < 4);
            out_ready_i = (c != 2);
            @(negedge clock);
            if (out_valid_o && out_pc_o == 32'h201) hold1++;
            if (out_valid_o && out_ready_i) em.push_back(out_pc_o);
            if (in_valid_i && in_ready_o) k++;
            model_tick();
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        chk("t6_count", 128'(em.size()), 128'd4);
        for (int j = 0; j < em.size(); j++) chk("t6_order", em[j], 32'h200 + 32'(j));
        chk("t6_hold", 128'(hold1), 128'd2);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            in_valid_i    = ($urandom_range(0, 9) < 6);
            in_pc_i       = $urandom;
            in_rs1_i      = 5'($urandom_range(0, 7));
            in_rs2_i      = 5'($urandom_range(0, 7));
            in_rs1_en_i   = ($urandom_range(0, 3) != 0);
            in_rs2_en_i   = ($urandom_range(0, 3) != 0);
            in_csr_addr_i = 12'h300 + 12'($urandom_range(0, 3));
            in_csr_en_i   = ($urandom_range(0, 2) == 0);
            in_payload_i  = {$urandom, $urandom, $urandom};
            flush_i       = ($urandom_range(0, 15) == 0);
            out_ready_i   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NF; i++) begin
                fwd_valid_i[i]    = ($urandom_range(0, 1) == 1);
                fwd_rd_we_i[i]    = ($urandom_range(0, 3) != 0);
                fwd_rd_i[i*RA +: RA] = 5'($urandom_range(0, 7));
                fwd_data_rdy_i[i] = ($urandom_range(0, 3) != 0);
                fwd_data_i[i*XLEN +: XLEN] = $urandom;
                fwd_csr_we_i[i]   = ($urandom_range(0, 5) == 0);
                fwd_csr_addr_i[i*CA +: CA] = 12'h300 + 12'($urandom_range(0, 3));
            end
            if (c % 50 == 0) csr_salt = $urandom;
            @(negedge clock);
            model_tick();
        end
        flush_i = 1'b0; in_valid_i = 1'b0; clr_fwd();

        // Asynchronous reset while holding an entry.
        load(32'h300, 5'd3, 1'b1, 5'd0, 1'b0, 12'h0, 1'b0); out_ready_i = 1'b0;
        @(negedge clock); model_tick();
        in_valid_i = 1'b0;
        @(negedge clock); chk("t7_held", out_valid_o, 1'b1); model_tick();
        #2 reset = 1'b0;
        #1;
        chk("t7_rst_ov", out_valid_o, 1'b0);
        chk("t7_rst_ready", in_ready_o, 1'b1);
        m_valid = 1'b0; m_stall = 32'd0; m_ldu = 32'd0;
        @(negedge clock); reset = 1'b1; out_ready_i = 1'b1;
        @(posedge clock); #1;
        load(32'h304, 5'd3, 1'b1, 5'd0, 1'b0, 12'h0, 1'b0);
        @(negedge clock); model_tick();
        in_valid_i = 1'b0;
        @(negedge clock);
        chk("t7_first_ov", out_valid_o, 1'b1);
        chk("t7_first_pc", out_pc_o, 32'h304);
        model_tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
